// File: rtl/nrs_pkg.sv
// nrs_pkg: shared constants and FSM state type for the NRS sequence checker.
package nrs_pkg;
    localparam int LFSR_W     = 31;
    localparam int SEED_W     = 28;
    localparam int LEN_W      = 8;
    localparam int NC_DEFAULT = 1600;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WARMUP = 2'd1,
        CHECK  = 2'd2,
        DONE   = 2'd3
    } state_t;
endpackage

// File: rtl/gold_seq_gen.sv
// gold_seq_gen: the two 31-bit LFSRs of the length-31 Gold sequence.
// Bit k of each register holds x(n+k); new bits enter at bit 30, so the
// current sequence bit c(n) is simply x1[0]^x2[0].
module gold_seq_gen
    import nrs_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic              adv,
    input  logic [SEED_W-1:0] seed,
    output logic              c
);
    logic [LFSR_W-1:0] x1;
    logic [LFSR_W-1:0] x2;

    // Load the initial state, or step both recurrences by one position.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            x1 <= '0;
            x2 <= '0;
        end else if (load) begin
            x1 <= 31'd1;
            x2 <= {3'b000, seed};
        end else if (adv) begin
            x1 <= {x1[3] ^ x1[0], x1[LFSR_W-1:1]};
            x2 <= {x2[3] ^ x2[2] ^ x2[1] ^ x2[0], x2[LFSR_W-1:1]};
        end
    end

    assign c = x1[0] ^ x2[0];
endmodule

// File: rtl/nrs_seq_checker.sv
// nrs_seq_checker: warms up a Gold generator by NC shifts, then compares
// len received bits against it and reports the mismatch count.
// Optional feature macro: NRS_CHK_FIRST_ERR_EN adds first_err_vld/first_err_idx.
module nrs_seq_checker
    import nrs_pkg::*;
#(
    parameter int NC = NC_DEFAULT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [SEED_W-1:0] seed,
    input  logic [LEN_W-1:0]  len,
    input  logic              rx_bit,
    input  logic              rx_valid,
    output logic              busy,
    output logic              ready,
    output logic              done,
    output logic              pass,
    output logic [LEN_W-1:0]  err_cnt
`ifdef NRS_CHK_FIRST_ERR_EN
    ,
    output logic              first_err_vld,
    output logic [LEN_W-1:0]  first_err_idx
`endif
);
    localparam int WCW = $clog2(NC + 1);

    state_t           state, state_nx;
    logic [WCW-1:0]   wcnt;
    logic [LEN_W-1:0] bcnt;
    logic [LEN_W-1:0] len_q;
    logic             load, adv, consume, mismatch, c;
    logic             wc_last, wc_full;

    gold_seq_gen u_gold (
        .clk  (clk),
        .rst  (rst),
        .load (load),
        .adv  (adv),
        .seed (seed),
        .c    (c)
    );

    assign wc_last  = (wcnt == WCW'(NC - 1));
    assign wc_full  = (wcnt == WCW'(NC));
    assign mismatch = consume && (rx_bit != c);

    assign busy  = (state == WARMUP) || (state == CHECK);
    assign ready = (state == CHECK) && (bcnt != len_q);
    assign done  = (state == DONE);

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    // Next state and generator controls. A len=0 run spends one extra
    // WARMUP cycle (wcnt==NC) in place of the empty CHECK phase, so every
    // run ends 1+NC+len+1 cycles after start without ever raising ready.
    always_comb begin
        state_nx = state;
        load     = 1'b0;
        adv      = 1'b0;
        consume  = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    load     = 1'b1;
                    state_nx = WARMUP;
                end
            end
            WARMUP: begin
                if (wc_full) begin
                    state_nx = DONE;
                end else begin
                    adv = 1'b1;
                    if (wc_last && (len_q != '0)) state_nx = CHECK;
                end
            end
            CHECK: begin
                if (bcnt == len_q) begin
                    state_nx = DONE;
                end else if (rx_valid) begin
                    consume = 1'b1;
                    adv     = 1'b1;
                end
            end
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Run counters, error count and verdict.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wcnt    <= '0;
            bcnt    <= '0;
            len_q   <= '0;
            err_cnt <= '0;
            pass    <= 1'b0;
        end else begin
            if (load) begin
                wcnt    <= '0;
                bcnt    <= '0;
                len_q   <= len;
                err_cnt <= '0;
                pass    <= 1'b0;
            end
            if (adv && (state == WARMUP)) wcnt <= wcnt + WCW'(1);
            if (consume) bcnt <= bcnt + 8'd1;
            if (mismatch) err_cnt <= err_cnt + 8'd1;
            // err_cnt is final here: no bit is consumed on the exit cycle.
            if ((state != DONE) && (state_nx == DONE)) pass <= (err_cnt == '0);
        end
    end

`ifdef NRS_CHK_FIRST_ERR_EN
    // Capture the index of the first mismatching bit of the run.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            first_err_vld <= 1'b0;
            first_err_idx <= '0;
        end else if (load) begin
            first_err_vld <= 1'b0;
            first_err_idx <= '0;
        end else if (mismatch && !first_err_vld) begin
            first_err_vld <= 1'b1;
            first_err_idx <= bcnt;
        end
    end
`endif
endmodule

// File: tb/tb_nrs_seq_checker.sv
// tb_nrs_seq_checker: directed runs against a run-level model that builds the
// Gold sequence from its recurrences and predicts outputs from run timing.
module tb_nrs_seq_checker;
    import nrs_pkg::*;

    localparam int NC   = 1600;
    localparam int MAXB = 256;

    logic        clk, rst, start, rx_bit, rx_valid;
    logic [27:0] seed;
    logic [7:0]  len, err_cnt;
    logic        busy, ready, done, pass;
`ifdef NRS_CHK_FIRST_ERR_EN
    logic        first_err_vld;
    logic [7:0]  first_err_idx;
`endif

    nrs_seq_checker #(.NC(NC)) dut (
        .clk(clk), .rst(rst), .start(start), .seed(seed), .len(len),
        .rx_bit(rx_bit), .rx_valid(rx_valid), .busy(busy), .ready(ready),
        .done(done), .pass(pass), .err_cnt(err_cnt)
`ifdef NRS_CHK_FIRST_ERR_EN
        , .first_err_vld(first_err_vld), .first_err_idx(first_err_idx)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int ncmp = 0;
    int nfail = 0;

    task automatic chk(input string nm, input int act, input int exp);
        ncmp++;
        if (act != exp) begin
            nfail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // ---------------- model ----------------
    bit gold [MAXB];
    bit flip [MAXB];
    bit x1a [NC+MAXB+31];
    bit x2a [NC+MAXB+31];

    function automatic void build_gold(input logic [27:0] sd);
        for (int k = 0; k < 31; k++) begin
            x1a[k] = (k == 0);
            x2a[k] = (k < 28) ? sd[k] : 1'b0;
        end
        for (int n = 0; n + 31 < NC + MAXB + 31; n++) begin
            x1a[n+31] = x1a[n+3] ^ x1a[n];
            x2a[n+31] = x2a[n+3] ^ x2a[n+2] ^ x2a[n+1] ^ x2a[n];
        end
        for (int i = 0; i < MAXB; i++) gold[i] = x1a[i+NC] ^ x2a[i+NC];
    endfunction

    int ecnt = 0;
    bit m_act, m_lastk, m_pass, m_fvld;
    int m_s, m_len, m_cons, m_errs, m_last, m_fidx;

    // Run-level model: a run starts at edge s, bits are consumable from edge
    // s+NC+1, done follows one cycle after the last bit (or after warm-up).
    always @(posedge clk) begin
        ecnt++;
        if (rst) begin
            m_act = 0; m_lastk = 0; m_pass = 0; m_fvld = 0;
            m_s = 0; m_len = 0; m_cons = 0; m_errs = 0; m_last = 0; m_fidx = 0;
        end else begin
            if (m_act && m_lastk && ecnt == m_last + 2) begin
                m_act = 0;
            end else if (!m_act && start) begin
                m_act = 1; m_s = ecnt; m_len = int'(len); m_cons = 0; m_errs = 0;
                m_pass = 0; m_fvld = 0; m_fidx = 0;
                build_gold(seed);
                m_lastk = (len == 0);
                m_last = ecnt + NC;
            end
            if (m_act && rx_valid && ecnt >= m_s + NC + 1 && m_cons < m_len) begin
                if (rx_bit != gold[m_cons]) begin
                    if (!m_fvld) begin m_fvld = 1; m_fidx = m_cons; end
                    m_errs++;
                end
                m_cons++;
                if (m_cons == m_len) begin m_lastk = 1; m_last = ecnt; end
            end
            if (m_act && m_lastk && ecnt == m_last + 1) m_pass = (m_errs == 0);
        end
    end

    // Every-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        bit eb, er, ed;
        if (rst) begin
            chk("rst.busy", busy, 0);   chk("rst.ready", ready, 0);
            chk("rst.done", done, 0);   chk("rst.err", err_cnt, 0);
            chk("rst.pass", pass, 0);
`ifdef NRS_CHK_FIRST_ERR_EN
            chk("rst.fvld", first_err_vld, 0); chk("rst.fidx", first_err_idx, 0);
`endif
        end else begin
            ed = m_act && m_lastk && (ecnt == m_last + 1);
            eb = m_act && !(m_lastk && ecnt >= m_last + 1);
            er = m_act && (ecnt >= m_s + NC) && (m_cons < m_len);
            chk("busy", busy, eb);  chk("ready", ready, er);
            chk("done", done, ed);  chk("err_cnt", err_cnt, m_errs);
            chk("pass", pass, m_pass);
`ifdef NRS_CHK_FIRST_ERR_EN
            chk("fvld", first_err_vld, m_fvld); chk("fidx", first_err_idx, m_fidx);
`endif
        end
    end

    // ---------------- stimulus ----------------
    int vmode = 0;

    // Receive-stream driver: the correct Gold bit for the next index, with
    // deliberately inverted positions taken from flip[].
    initial begin
        rx_bit = 0; rx_valid = 0;
        forever begin
            @(posedge clk); #1;
            rx_bit   = (m_cons < MAXB) ? (gold[m_cons] ^ flip[m_cons]) : 1'b0;
            rx_valid = (vmode == 0) ? 1'b1 : ((ecnt % 2) == 1);
        end
    end

    task automatic step();
        @(posedge clk); #2;
    endtask

    task automatic clr_flips();
        for (int i = 0; i < MAXB; i++) flip[i] = 0;
    endtask

    // One run: start, optionally re-pulse start k cycles into CHECK, wait for done.
    task automatic run(input logic [27:0] sd, input int ln, input int again,
                       output int lat, output int errs, output int p,
                       output int gaps, output int rdy);
        int s;
        bit got;
        lat = -1; errs = -1; p = -1; gaps = 0; rdy = 0; got = 0;
        start = 1; seed = sd; len = 8'(ln);
        step();
        start = 0;
        s = ecnt;
        for (int c = 0; c < 3000 && !got; c++) begin
            @(negedge clk);
            start = (again > 0 && ecnt == s + NC + again);
            if (ready && !rx_valid) gaps++;
            if (ready) rdy++;
            if (done) begin
                got = 1; lat = ecnt + 1 - s; errs = err_cnt; p = pass;
            end
        end
        start = 0;
        if (!got) chk("done_timeout", 0, 1);
        step();
    endtask

    initial begin
        int lat, errs, p, gaps, rdy, lat_c, errs_c;
        rst = 1; start = 0; seed = '0; len = '0;
        clr_flips();
        repeat (3) step();
        @(negedge clk);
        chk("reset.busy", busy, 0); chk("reset.err", err_cnt, 0); chk("reset.pass", pass, 0);
        rst = 0;
        repeat (3) step();
        chk("idle_no_autorun", busy, 0);

        // Correct stream, len=12.
        run(28'h0ABCDEF, 12, 0, lat, errs, p, gaps, rdy);
        chk("t1.latency", lat, 1 + 1600 + 12 + 1);
        chk("t1.err", errs, 0); chk("t1.pass", p, 1); chk("t1.ready_cycles", rdy, 12);

        // Bit 5 inverted.
        flip[5] = 1;
        run(28'h0ABCDEF, 12, 0, lat, errs, p, gaps, rdy);
        chk("t2.err", errs, 1); chk("t2.pass", p, 0);
`ifdef NRS_CHK_FIRST_ERR_EN
        chk("t2.fidx", first_err_idx, 5); chk("t2.fvld", first_err_vld, 1);
`endif
        clr_flips();

        // len=0.
        flip[0] = 1;
        run(28'h0000001, 0, 0, lat, errs, p, gaps, rdy);
        chk("t3.latency", lat, 1 + 1600 + 1);
        chk("t3.pass", p, 1); chk("t3.err", errs, 0); chk("t3.no_ready", rdy, 0);
        clr_flips();

        // len=8 contiguous vs gapped, bits 2 and 6 inverted.
        flip[2] = 1; flip[6] = 1;
        run(28'h0FFFFFF, 8, 0, lat_c, errs_c, p, gaps, rdy);
        chk("t4c.latency", lat_c, 1 + 1600 + 8 + 1);
        chk("t4c.err", errs_c, 2);
        vmode = 1;
        run(28'h0FFFFFF, 8, 0, lat, errs, p, gaps, rdy);
        vmode = 0;
        chk("t4g.err_same", errs, errs_c);
        chk("t4g.pass", p, 0);
        chk("t4g.gaps_seen", int'(gaps > 0), 1);
        chk("t4g.latency", lat, lat_c + gaps);
        clr_flips();

        // Reset at warm-up cycle 800, then a fresh run.
        start = 1; seed = 28'h0ABCDEF; len = 8'd12;
        step();
        start = 0;
        repeat (800) step();
        chk("t5.busy_mid_warmup", busy, 1);
        rst = 1;
        step();
        chk("t5.busy_in_rst", busy, 0);
        step();
        rst = 0;
        step();
        flip[9] = 1;
        run(28'h1234567, 10, 0, lat, errs, p, gaps, rdy);
        chk("t5.latency", lat, 1 + 1600 + 10 + 1);
        chk("t5.err", errs, 1); chk("t5.pass", p, 0);
`ifdef NRS_CHK_FIRST_ERR_EN
        chk("t5.fidx", first_err_idx, 9);
`endif
        clr_flips();

        // start re-pulsed five cycles into CHECK.
        flip[0] = 1;
        run(28'h0ABCDEF, 12, 5, lat, errs, p, gaps, rdy);
        chk("t6.latency", lat, 1 + 1600 + 12 + 1);
        chk("t6.err", errs, 1); chk("t6.pass", p, 0);
        repeat (3) step();
        chk("t6.no_restart", busy, 0);
        clr_flips();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end
endmodule

// File: doc/nrs_seq_checker.md
NRS_SEQ_CHECKER -- requirements
Module: nrs_seq_checker

Interface
REQ-001 SHALL have parameter NC, default 1600, giving the Gold-sequence warm-up offset in shift cycles.
REQ-002 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-004 SHALL have port start, input, 1, a one-cycle request to begin a check run; sampled only in IDLE.
REQ-005 SHALL have port seed, input, 28, c_init loaded into x2 on start.
REQ-006 SHALL have port len, input, 8, the number of bits to check; sampled on start.
REQ-007 SHALL have port rx_bit, input, 1, the received NRS sequence bit.
REQ-008 SHALL have port rx_valid, input, 1, which qualifies rx_bit.
REQ-009 SHALL have port busy, output, 1, high in WARMUP and CHECK.
REQ-010 SHALL have port ready, output, 1, high only in CHECK, meaning rx_bit is being consumed.
REQ-011 SHALL have port done, output, 1, a one-cycle pulse at end of run.
REQ-012 SHALL have port pass, output, 1, high when err_cnt==0; valid from the done pulse until the next start.
REQ-013 SHALL have port err_cnt, output, 8, the mismatch count of the current or last run.

Function
REQ-014 SHALL generate c(n)=x1(n+NC) xor x2(n+NC), with x1(n+31)=x1(n+3)^x1(n) and x2(n+31)=x2(n+3)^x2(n+2)^x2(n+1)^x2(n).
REQ-015 SHALL hold each 31-bit LFSR so that bit k equals x(n+k), with the new bit entering at bit 30.
REQ-016 SHALL implement FSM states IDLE, WARMUP, CHECK and DONE.
REQ-017 SHALL, in IDLE with start=1, load x1=31'd1, x2={3'b0,seed}, latch len, clear err_cnt, zero the warm-up counter and go to WARMUP.
REQ-018 SHALL advance both LFSRs every cycle in WARMUP, and go to CHECK after exactly NC advances.
REQ-019 SHALL, in CHECK, on each cycle with rx_valid=1, compare rx_bit with x1[0]^x2[0], increment err_cnt on mismatch, advance both LFSRs and increment the bit counter.
REQ-020 SHALL hold both LFSRs and all counters in CHECK on cycles with rx_valid=0.
REQ-021 SHALL go from CHECK to DONE in the cycle after the bit counter reaches len.
REQ-022 SHALL, when len=0, go straight from WARMUP to DONE, with err_cnt=0 and pass=1.
REQ-023 SHALL assert done for exactly one cycle in DONE and then return to IDLE.
REQ-024 SHALL ignore start outside IDLE, with no restart.
REQ-025 SHALL ignore rx_valid outside CHECK, with no count and no shift.
REQ-026 SHALL not saturate err_cnt, because err_cnt cannot exceed len (at most 255).
REQ-027 SHALL have a latency from the start cycle to the first bit consumable of 1+NC cycles.

Reset
REQ-028 SHALL, on rst=1 at any time (including mid-WARMUP or mid-CHECK), immediately force IDLE, LFSRs=0, counters=0, busy=0, ready=0, done=0, err_cnt=0 and pass=0.
REQ-029 SHALL require the first run after reset to be started by start; no automatic run occurs.

Configuration
REQ-030 SHALL, with macro NRS_CHK_FIRST_ERR_EN defined, add outputs first_err_vld (1) and first_err_idx (8).
REQ-031 SHALL, with NRS_CHK_FIRST_ERR_EN defined, latch the bit-counter value of the first mismatch in a run and set first_err_vld.
REQ-032 SHALL, with NRS_CHK_FIRST_ERR_EN defined, clear first_err_vld and first_err_idx on start and on reset.
REQ-033 SHALL, with NRS_CHK_FIRST_ERR_EN undefined, omit those ports and registers, leaving behaviour otherwise identical.

Structure
REQ-034 SHALL place in a shared package nrs_pkg the constants LFSR_W=31, SEED_W=28, NC_DEFAULT=1600, and the state enum IDLE/WARMUP/CHECK/DONE.
REQ-035 SHALL use one sub-module, gold_seq_gen, holding x1 and x2 with load/advance controls and output c.
REQ-036 SHALL keep the FSM, counters and compare logic in nrs_seq_checker itself.

Verification
REQ-037 SHALL cover: seed=28'h0ABCDEF, len=12, correct stream with rx_valid held high -> done at start+1+1600+12+1, err_cnt=0, pass=1.
REQ-038 SHALL cover: the same run with bit 5 inverted -> err_cnt=1, pass=0, first_err_idx=5 with first_err_vld=1 (macro on).
REQ-039 SHALL cover: len=0 -> done at start+1+1600+1, pass=1, and no rx_bit consumed.
REQ-040 SHALL cover: rx_valid toggled 1/0 during CHECK with len=8 -> result identical to the contiguous run, and done delayed by the number of gap cycles.
REQ-041 SHALL cover: rst pulsed at WARMUP cycle 800, then a new start -> a full 1600-cycle warm-up repeats and the result matches the golden model.
REQ-042 SHALL cover: start pulsed during CHECK -> ignored; err_cnt and timing are unchanged.
